// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full adder cell, reused every cycle by serial_adder_ctrl.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first, one bit per clock, valid/ready on both sides.
// Optional subtract mode (adds the sub port) when SERIAL_SUB_EN is defined.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             accept;
    logic             step;
    logic             last;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_SUB_EN
    // Subtract as a + ~b + 1; cout then reads as "no borrow".
    assign b_load = sub ? ~b : b;
    assign c_load = sub | cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    fa_bit u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign sum_nxt = {s_bit, sum_sr};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_nxt[WIDTH-1:1];
            carry  <= c_bit;
            if (last) begin
                sum  <= sum_nxt;
                cout <= c_bit;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: random and directed operands.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_SUB_EN
    logic         sub = 1'b0;
`endif

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = -1;
    int busy_run = 0;
    int done_run = 0;
    bit ov_prev = 1'b0;
    bit hold5 = 1'b0;
    logic [W:0] held = '0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_SUB_EN
        ,
        .sub       (sub)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_model(input int unsigned x, input int unsigned y,
                                             input int unsigned c, input bit s);
        int unsigned r;
        if (s) begin
            r = (x - y) & ((1 << W) - 1);
            return {(x >= y) ? 1'b1 : 1'b0, r[W-1:0]};
        end
        r = x + y + c;
        return r[W:0];
    endfunction

    // Consumer: random backpressure, or a forced five-cycle stall in DONE.
    always @(posedge clk) begin
        #1;
        if (hold5) out_ready = (done_run >= 5);
        else out_ready = ($urandom_range(3) != 0);
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
            done_run = 0;
            ov_prev = 1'b0;
        end else begin
            chk("ready_vs_busy", in_ready, !busy);
            if (busy) busy_run++;
            else busy_run = 0;
            if (out_valid) begin
                done_run++;
                if (!ov_prev) begin
                    held = {cout, sum};
                    if (sbq.size() == 0) chk("spurious_valid", 1, 0);
                    else chk("latency", cyc - sbq[0].acc, W);
                end else begin
                    chk("done_stable", {cout, sum}, held);
                end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", {cout, sum}, e.res);
                        chk("busy_len", busy_run, W + done_run);
                    end
                    done_run = 0;
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit is);
        int t = 0;
        int acc;
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        cin = ic;
`ifdef SERIAL_SUB_EN
        sub = is;
`endif
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e.acc = acc;
`ifdef SERIAL_SUB_EN
        e.res = ref_model(ia, ib, ic, is);
`else
        e.res = ref_model(ia, ib, ic, 1'b0);
`endif
        sbq.push_back(e);
        if (last_acc >= 0) chk("issue_gap", (acc - last_acc) >= (W + 2), 1);
        last_acc = acc;
        in_valid = 1'b0;
    endtask

    initial begin
        int t;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h5A, 8'h3C, 1'b1, 1'b0);

        hold5 = 1'b1;
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        issue(8'hC8, 8'h64, 1'b1, 1'b0);
        issue(8'h80, 8'h80, 1'b1, 1'b0);
        hold5 = 1'b0;

        // Abort after the third shift.
        issue(8'hAA, 8'h55, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        last_acc = -1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        issue(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h02, 1'b1, 1'b1);
        issue(8'h7F, 8'h7F, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(1) == 1));
        end
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b0, 1'b0);

        t = 0;
        while (sbq.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sbq.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
